onchip_mem_test_master: RTL and testbench

// - Avalon-MM master that drives the on-chip RAM slave port: fills a word range with a

---
 rtl/onchip_mem_test_master.sv | 231 +++++++++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_test_master.sv
// ============================================================================
// Module      : onchip_mem_test_master
// Description : Avalon-MM master for on-chip RAM self-test. It writes a
//               seed-derived pattern over a word range, reads the range back
//               with pipelined reads and counts the mismatches.
//               Optional feature macro: MEMTEST_ERRLOG_EN (first-error capture).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_test_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
`ifdef MEMTEST_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [DATA_W-1:0]     first_err_data
`endif
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   count_r;
  logic [ADDR_W-1:0]  base_r;
  logic [DATA_W-1:0]  seed_r;
  logic               accept;
  logic               push;
  logic               mism;
  logic [CNT_W-1:0]   err_next;
  logic [DATA_W-1:0]  pat;

  // Expected-data shift line: one stage per clock of slave read latency
  logic [READ_LATENCY-1:0] line_vld;
  logic [DATA_W-1:0]       line_exp  [READ_LATENCY];
  logic [ADDR_W-1:0]       line_addr [READ_LATENCY];

  // Pattern word: low half is the offset, high half its inverse, xor seed
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [CNT_W-1:0]  i);
    logic [CNT_W-1:0]  inv;
    logic [HALF_W-1:0] lo;
    logic [HALF_W-1:0] hi;
    inv = ~i;
    lo  = HALF_W'(i);
    hi  = HALF_W'(inv);
    return s ^ DATA_W'({hi, lo});
  endfunction

  assign pat            = pattern(seed_r, idx);
  assign avm_write      = (state == S_WRITE);
  assign avm_read       = (state == S_READ);
  assign avm_chipselect = avm_write | avm_read;
  assign avm_byteenable = '1;
  assign avm_address    = avm_chipselect ? (base_r + ADDR_W'(idx)) : '0;
  assign avm_writedata  = avm_write ? pat : '0;
  assign busy           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done           = (state == S_DONE);

  assign push     = avm_read & ~avm_waitrequest;
  assign mism     = line_vld[READ_LATENCY-1] && (avm_readdata != line_exp[READ_LATENCY-1]);
  assign err_next = (mism && !(&err_count)) ? err_count + CNT_W'(1) : err_count;

  // State and word-offset registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: phase sequencing and offset advance on accepted beats
  always_comb begin
    state_n = state;
    idx_n   = idx;
    accept  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          idx_n   = '0;
          state_n = (word_count == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (idx == count_r - CNT_W'(1)) begin
            state_n = S_READ;
            idx_n   = '0;
          end else begin
            idx_n = idx + CNT_W'(1);
          end
        end
      end
      S_READ: begin
        if (!avm_waitrequest) begin
          if (idx == count_r - CNT_W'(1)) begin
            state_n = S_DRAIN;
            idx_n   = '0;
          end else begin
            idx_n = idx + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (idx == DRAIN_LAST) begin
          state_n = S_DONE;
        end else begin
          idx_n = idx + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Run parameters captured when a start is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      base_r  <= '0;
      seed_r  <= '0;
    end else if (accept) begin
      count_r <= word_count;
      base_r  <= base_addr;
      seed_r  <= seed;
    end
  end

  // Error counter and pass flag; pass includes the final compare of the run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      pass      <= (word_count == '0);
    end else begin
      err_count <= err_next;
      if (state == S_DRAIN && state_n == S_DONE) begin
        pass <= (err_next == '0);
      end
    end
  end

  // Head of the shift line, loaded by each accepted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_vld[0]  <= 1'b0;
      line_exp[0]  <= '0;
      line_addr[0] <= '0;
    end else begin
      line_vld[0]  <= push;
      line_exp[0]  <= pat;
      line_addr[0] <= avm_address;
    end
  end

  generate
    for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
      // Remaining stages shift every clock, independent of waitrequest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          line_vld[k]  <= 1'b0;
          line_exp[k]  <= '0;
          line_addr[k] <= '0;
        end else begin
          line_vld[k]  <= line_vld[k-1];
          line_exp[k]  <= line_exp[k-1];
          line_addr[k] <= line_addr[k-1];
        end
      end
    end
  endgenerate

`ifdef MEMTEST_ERRLOG_EN
  // Capture address and data of the first mismatch of a run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (accept) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mism && err_count == '0) begin
      first_err_addr <= line_addr[READ_LATENCY-1];
      first_err_data <= avm_readdata;
    end
  end
`else
  // Line address only feeds the error log; fold it away when that is absent
  logic unused_addr;
  assign unused_addr = ^line_addr[READ_LATENCY-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_test_master.sv
// ============================================================================
// Module      : tb_onchip_mem_test_master
// Description : Self-checking bench for onchip_mem_test_master with a RAM
//               model, optional fault injection and random waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_test_master;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int CW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic          avm_chipselect, avm_write, avm_read;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
`ifdef MEMTEST_ERRLOG_EN
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
`endif

  onchip_mem_test_master #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
`ifdef MEMTEST_ERRLOG_EN
    , .first_err_addr(first_err_addr), .first_err_data(first_err_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_waddr_q[$];
  logic [DW-1:0] exp_wdata_q[$];
  logic [AW-1:0] exp_raddr_q[$];
  logic [DW-1:0] rsp_q[$];
  int            rsp_due_q[$];
  int            cyc = 0;
  bit            rand_wait = 0;
  bit            fault = 0;
  bit            prev_stall = 0;
  logic [AW+DW+1:0] prev_req;
  int            n_wr, n_rd;
  logic [DW-1:0] first_wdata, wdata_at5;
  logic [AW-1:0] first_waddr, first_raddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pattern from the rule: low 16 bits = offset, high 16 bits = 15-bit inverse of offset
  function automatic logic [DW-1:0] model_pattern(input logic [DW-1:0] s, input int i);
    return s ^ (((32'h7FFF - i) << 16) | i);
  endfunction

  // RAM slave model and per-cycle protocol checks, all at the falling edge
  always @(negedge clk) begin
    cyc++;
    avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rsp_due_q.size() > 0 && rsp_due_q[0] == cyc) begin
      avm_readdata = rsp_q.pop_front();
      void'(rsp_due_q.pop_front());
    end else begin
      avm_readdata = $urandom;
    end
    if (!reset) begin
      check("chipselect", avm_chipselect, avm_read | avm_write);
      check("byteenable", avm_byteenable, 4'hF);
      check("rd_wr_excl", avm_read & avm_write, 1'b0);
      if (prev_stall)
        check("stall_stable", {avm_read, avm_write, avm_address, avm_writedata}, prev_req);
      if (avm_write && !avm_waitrequest) begin
        if (exp_waddr_q.size() == 0) begin
          check("wr_unexpected", 1'b1, 1'b0);
        end else begin
          check("wr_addr", avm_address, exp_waddr_q.pop_front());
          check("wr_data", avm_writedata, exp_wdata_q.pop_front());
        end
        if (n_wr == 0) begin
          first_wdata = avm_writedata;
          first_waddr = avm_address;
        end
        if (avm_address == 5) wdata_at5 = avm_writedata;
        mem[avm_address] = avm_writedata;
        n_wr++;
      end
      if (avm_read && !avm_waitrequest) begin
        if (exp_raddr_q.size() == 0) begin
          check("rd_unexpected", 1'b1, 1'b0);
        end else begin
          check("rd_addr", avm_address, exp_raddr_q.pop_front());
        end
        if (n_rd == 0) first_raddr = avm_address;
        rsp_q.push_back(mem[avm_address] ^ ((fault && avm_address == 5) ? 32'h8 : 32'h0));
        rsp_due_q.push_back(cyc + RL);
        n_rd++;
      end
      prev_stall = (avm_read | avm_write) & avm_waitrequest;
      prev_req   = {avm_read, avm_write, avm_address, avm_writedata};
    end else begin
      prev_stall = 0;
    end
  end

  task automatic prepare(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                         input bit f, input bit rw, output int exp_err);
    fault = f;
    rand_wait = rw;
    exp_waddr_q.delete(); exp_wdata_q.delete(); exp_raddr_q.delete();
    rsp_q.delete(); rsp_due_q.delete();
    n_wr = 0; n_rd = 0;
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      exp_waddr_q.push_back(AW'((b + i) % (1 << AW)));
      exp_wdata_q.push_back(model_pattern(s, i));
      exp_raddr_q.push_back(AW'((b + i) % (1 << AW)));
      if (f && ((b + i) % (1 << AW)) == 5) exp_err++;
    end
  endtask

  task automatic run_test(input logic [AW-1:0] b, input int n, input logic [DW-1:0] s,
                          input bit f, input bit rw, input bit poke);
    int exp_err;
    int k;
    prepare(b, n, s, f, rw, exp_err);
    @(negedge clk);
    base_addr = b; word_count = CW'(n); seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    #1;
    if (n > 0) check("started_busy_not_done", {busy, done}, 2'b10);
    while (!done && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
      if (poke && k == 3) begin
        base_addr = 999; word_count = 5; start = 1'b1;
      end else if (poke && k == 4) begin
        start = 1'b0;
      end
    end
    check("done_reached", done, 1'b1);
    if (!rw) check("cycles_to_done", k, (n == 0) ? 1 : 2 * n + RL + 1);
    check("pass", pass, exp_err == 0);
    check("err_count", err_count, exp_err);
    check("busy_at_done", busy, 1'b0);
    check("writes_done", n_wr, n);
    check("reads_done", n_rd, n);
    check("wr_queue_empty", exp_waddr_q.size(), 0);
    check("rd_queue_empty", exp_raddr_q.size(), 0);
  endtask

  initial begin
    int k;
    int dummy;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {busy, done, pass, avm_read, avm_write, avm_chipselect}, 6'b0);
    check("rst_err", err_count, 0);
    check("rst_addr_data", {avm_address, avm_writedata}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Ideal RAM, base 0, 16 words, seed 0
    run_test(0, 16, 32'h0, 0, 0, 0);
    check("pin_first_wdata", first_wdata, 32'h7FFF0000);
    check("pin_wdata_word5", wdata_at5, 32'h7FFA0005);
    check("pin_cycles", 2 * 16 + RL + 1, 35);

    // Stuck bit 3 at word 5
    run_test(0, 16, 32'h0, 1, 0, 0);
    check("fault_err_literal", err_count, 1);
    check("fault_pass_literal", pass, 1'b0);
`ifdef MEMTEST_ERRLOG_EN
    check("errlog_addr", first_err_addr, 5);
    check("errlog_data", first_err_data, 32'h7FFA000D);
`endif

    // Address wrap at the top of the space
    run_test(16380, 8, 32'hA5A55A5A, 0, 0, 0);
    check("wrap_first_waddr", first_waddr, 16380);
    check("wrap_first_raddr", first_raddr, 16380);

    // Random stalls, 64 words; fault lies outside the range
    run_test(100, 64, 32'h12345678, 1, 1, 0);

    // Zero words: immediate done, no requests
    run_test(0, 0, 32'hFFFFFFFF, 0, 0, 0);

    // Start while busy is ignored
    run_test(40, 16, 32'h0F0F0F0F, 0, 0, 1);

    // Reset in the read phase, then a clean rerun
    prepare(0, 16, 32'h0, 0, 0, dummy);
    @(negedge clk);
    base_addr = 0; word_count = 16; seed = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    #1;
    while (!avm_read && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reached_read", avm_read, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {busy, done, pass, avm_read, avm_write, avm_chipselect}, 6'b0);
    check("midrst_err", err_count, 0);
    check("midrst_addr_data", {avm_address, avm_writedata}, 0);
    @(negedge clk);
    reset = 1'b0;
    run_test(0, 16, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
